// File: rtl/jt10_adpcma_pkg.sv
// ---------------------------------------------------------------------------
// jt10_adpcma_pkg
// Shared definitions for the ADPCM-A control front-end:
//   - channel count / rate divider constants
//   - CPU register map bases
//   - channel index type and register decode helper
// ---------------------------------------------------------------------------
package jt10_adpcma_pkg;

    localparam int unsigned NCH  = 6;
    localparam int unsigned DIVN = 3;

    typedef logic [2:0] ch_t;

    localparam ch_t        LAST_CH    = 3'(NCH - 1);
    localparam logic [1:0] LAST_ROUND = 2'(DIVN - 1);

    // Register map bases; the low 3 address bits select the channel
    localparam logic [7:0] KEY_ADDR     = 8'h00;
    localparam logic [7:0] START_L_BASE = 8'h10;
    localparam logic [7:0] START_H_BASE = 8'h18;
    localparam logic [7:0] END_L_BASE   = 8'h20;
    localparam logic [7:0] END_H_BASE   = 8'h28;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_KEY,
        REG_START_L,
        REG_START_H,
        REG_END_L,
        REG_END_H
    } reg_kind_e;

    typedef struct packed {
        reg_kind_e kind;
        ch_t       idx;
    } reg_dec_t;

    // Classify a CPU address; channel indices above LAST_CH decode as REG_NONE
    function automatic reg_dec_t decode_addr(input logic [7:0] addr);
        reg_dec_t d;
        d.kind = REG_NONE;
        d.idx  = addr[2:0];
        if (addr == KEY_ADDR) begin
            d.kind = REG_KEY;
        end else if (addr[2:0] <= LAST_CH) begin
            case ({addr[7:3], 3'b000})
                START_L_BASE: d.kind = REG_START_L;
                START_H_BASE: d.kind = REG_START_H;
                END_L_BASE:   d.kind = REG_END_L;
                END_H_BASE:   d.kind = REG_END_H;
                default:      d.kind = REG_NONE;
            endcase
        end
        return d;
    endfunction

    function automatic ch_t next_ch(input ch_t c);
        return (c == LAST_CH) ? '0 : c + 3'd1;
    endfunction

endpackage

// File: rtl/jt10_adpcma_slot.sv
// ---------------------------------------------------------------------------
// jt10_adpcma_slot
// Slot rotation for the ADPCM-A pipeline: channel slot counter 0..NCH-1 and
// a round counter that advances on each slot wrap. div3 marks the last round.
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_cen           advance enable
//   o_ch_next       slot that becomes current on the next cen (combinational)
//   o_ch            current slot (registered)
//   o_div3          high during round DIVN-1 (registered)
// ---------------------------------------------------------------------------
module jt10_adpcma_slot
    import jt10_adpcma_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_cen,
    output ch_t  o_ch_next,
    output ch_t  o_ch,
    output logic o_div3
);

    ch_t        r_ch;
    logic [1:0] r_round;
    logic       r_div3;
    ch_t        w_ch_next;
    logic [1:0] w_round_next;

    always_comb begin
        w_ch_next    = next_ch(r_ch);
        w_round_next = r_round;
        if (r_ch == LAST_CH) begin
            w_round_next = (r_round == LAST_ROUND) ? '0 : r_round + 2'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ch    <= '0;
            r_round <= '0;
            r_div3  <= 1'b0;
        end else if (i_cen) begin
            r_ch    <= w_ch_next;
            r_round <= w_round_next;
            // registered from the next round value so it tracks r_round exactly
            r_div3  <= (w_round_next == LAST_ROUND);
        end
    end

    assign o_ch_next = w_ch_next;
    assign o_ch      = r_ch;
    assign o_div3    = r_div3;

endmodule

// File: rtl/jt10_adpcma_ctl.sv
// ---------------------------------------------------------------------------
// jt10_adpcma_ctl
// Register front-end and slot scheduler for the 6-channel ADPCM-A address
// counter. CPU writes fill per-channel shadow start/end registers and key
// on/off requests; each pending update is issued only in its channel's slot.
// Ports:
//   rst_n, clk          asynchronous active-low reset, clock
//   cen                 slot pipeline clock enable
//   cpu_we/addr/din     register write port (captured on every clk)
//   done, ch_done       end-of-sample pulse and its channel
//   flag_clr            per-channel level clear for flags
//   addr_in             start/end address for the current slot
//   up_start, up_end    load strobes for the current slot
//   aon, aoff           key-on / key-off for the current slot
//   ch                  channel owning the current slot
//   div3                rate divider qualifier
//   flags               sticky end-of-sample flags
//   busy                any update still pending
// ---------------------------------------------------------------------------
module jt10_adpcma_ctl
    import jt10_adpcma_pkg::*;
(
    input  logic        rst_n,
    input  logic        clk,
    input  logic        cen,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_addr,
    input  logic [7:0]  cpu_din,
    input  logic        done,
    input  logic [2:0]  ch_done,
    input  logic [5:0]  flag_clr,
    output logic [15:0] addr_in,
    output logic        up_start,
    output logic        up_end,
    output logic        aon,
    output logic        aoff,
    output logic [2:0]  ch,
    output logic        div3,
    output logic [5:0]  flags,
    output logic        busy
);

    logic [15:0]    r_start [NCH];
    logic [15:0]    r_end   [NCH];
    logic [NCH-1:0] r_pend_start, r_pend_end, r_pend_on, r_pend_off;
    logic [15:0]    r_addr;
    logic           r_up_start, r_up_end, r_aon, r_aoff;
    logic [5:0]     r_flags;

    reg_dec_t       w_dec;
    ch_t            w_ch_next;
    ch_t            w_ch;
    logic           w_div3;
    logic [NCH-1:0] w_set_start, w_set_end, w_key_on, w_key_off;
    logic [NCH-1:0] w_clr_start, w_clr_end, w_clr_on, w_clr_off;
    logic           w_iss_start, w_iss_end, w_iss_on, w_iss_off;
    logic [5:0]     w_flag_set;

    jt10_adpcma_slot u_slot (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_cen     (cen),
        .o_ch_next (w_ch_next),
        .o_ch      (w_ch),
        .o_div3    (w_div3)
    );

    // CPU write decode: pending-set vectors
    always_comb begin
        w_dec       = decode_addr(cpu_addr);
        w_set_start = '0;
        w_set_end   = '0;
        w_key_on    = '0;
        w_key_off   = '0;
        if (cpu_we) begin
            case (w_dec.kind)
                REG_KEY: begin
                    if (cpu_din[7]) w_key_off = cpu_din[5:0];
                    else            w_key_on  = cpu_din[5:0];
                end
                REG_START_L, REG_START_H: w_set_start[w_dec.idx] = 1'b1;
                REG_END_L, REG_END_H:     w_set_end[w_dec.idx]   = 1'b1;
                default: ;
            endcase
        end
    end

    // Issue decision for the slot about to become current. A pending start
    // blocks both end (shared addr_in) and key-on (restart must load start).
    always_comb begin
        w_iss_start = cen & r_pend_start[w_ch_next];
        w_iss_end   = cen & r_pend_end[w_ch_next] & ~r_pend_start[w_ch_next];
        w_iss_on    = cen & r_pend_on[w_ch_next]  & ~r_pend_start[w_ch_next];
        w_iss_off   = cen & r_pend_off[w_ch_next];
        w_clr_start = '0;
        w_clr_end   = '0;
        w_clr_on    = '0;
        w_clr_off   = '0;
        w_clr_start[w_ch_next] = w_iss_start;
        w_clr_end[w_ch_next]   = w_iss_end;
        w_clr_on[w_ch_next]    = w_iss_on;
        w_clr_off[w_ch_next]   = w_iss_off;
    end

    always_comb begin
        w_flag_set = '0;
        if (cen && done && (ch_done <= LAST_CH)) begin
            w_flag_set[ch_done] = 1'b1;
        end
    end

    // Shadow address registers; a rewrite simply overwrites the byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                r_start[i] <= '0;
                r_end[i]   <= '0;
            end
        end else if (cpu_we) begin
            case (w_dec.kind)
                REG_START_L: r_start[w_dec.idx][7:0]  <= cpu_din;
                REG_START_H: r_start[w_dec.idx][15:8] <= cpu_din;
                REG_END_L:   r_end[w_dec.idx][7:0]    <= cpu_din;
                REG_END_H:   r_end[w_dec.idx][15:8]   <= cpu_din;
                default: ;
            endcase
        end
    end

    // Pending bits: the set term is OR-ed last so a same-clk write survives
    // the issue clear. A key write also cancels the opposite key request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_start <= '0;
            r_pend_end   <= '0;
            r_pend_on    <= '0;
            r_pend_off   <= '0;
        end else begin
            r_pend_start <= (r_pend_start & ~w_clr_start) | w_set_start;
            r_pend_end   <= (r_pend_end   & ~w_clr_end)   | w_set_end;
            r_pend_on    <= (r_pend_on  & ~w_clr_on  & ~w_key_off) | w_key_on;
            r_pend_off   <= (r_pend_off & ~w_clr_off & ~w_key_on)  | w_key_off;
        end
    end

    // Slot outputs, registered together with the slot counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_up_start <= 1'b0;
            r_up_end   <= 1'b0;
            r_aon      <= 1'b0;
            r_aoff     <= 1'b0;
        end else if (cen) begin
            r_up_start <= w_iss_start;
            r_up_end   <= w_iss_end;
            r_aon      <= w_iss_on;
            r_aoff     <= w_iss_off;
            if (w_iss_start)    r_addr <= r_start[w_ch_next];
            else if (w_iss_end) r_addr <= r_end[w_ch_next];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_flags <= '0;
        else        r_flags <= (r_flags & ~flag_clr) | w_flag_set;
    end

    assign addr_in  = r_addr;
    assign up_start = r_up_start;
    assign up_end   = r_up_end;
    assign aon      = r_aon;
    assign aoff     = r_aoff;
    assign ch       = w_ch;
    assign div3     = w_div3;
    assign flags    = r_flags;
    assign busy     = |{r_pend_start, r_pend_end, r_pend_on, r_pend_off};

endmodule

// File: tb/tb_jt10_adpcma_ctl.sv
// ---------------------------------------------------------------------------
// tb_jt10_adpcma_ctl
// Self-checking bench for jt10_adpcma_ctl: a behavioural model compared every
// cycle, a table of register-pair writes, and directed corner sequences.
// ---------------------------------------------------------------------------
module tb_jt10_adpcma_ctl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cen = 1'b0;
    logic        cpu_we = 1'b0;
    logic [7:0]  cpu_addr = '0;
    logic [7:0]  cpu_din = '0;
    logic        done = 1'b0;
    logic [2:0]  ch_done = '0;
    logic [5:0]  flag_clr = '0;
    logic [15:0] addr_in;
    logic        up_start, up_end, aon, aoff, div3, busy;
    logic [2:0]  ch;
    logic [5:0]  flags;

    always #5 clk = ~clk;

    jt10_adpcma_ctl dut (
        .rst_n    (rst_n),
        .clk      (clk),
        .cen      (cen),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_din  (cpu_din),
        .done     (done),
        .ch_done  (ch_done),
        .flag_clr (flag_clr),
        .addr_in  (addr_in),
        .up_start (up_start),
        .up_end   (up_end),
        .aon      (aon),
        .aoff     (aoff),
        .ch       (ch),
        .div3     (div3),
        .flags    (flags),
        .busy     (busy)
    );

    int   n_vec = 0;
    int   n_err = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic [15:0] m_start [6];
    logic [15:0] m_end   [6];
    bit          m_ps [6], m_pe [6], m_pon [6], m_poff [6];
    logic [15:0] m_addr;
    bit          m_us, m_ue, m_aon, m_aoff, m_div3;
    int          m_ch, m_round, mn, ma, mc;
    logic [5:0]  m_flags;

    function automatic bit m_busy();
        bit b = 0;
        for (int c = 0; c < 6; c++) b = b | m_ps[c] | m_pe[c] | m_pon[c] | m_poff[c];
        return b;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 6; c++) begin
                m_start[c] = 0; m_end[c] = 0;
                m_ps[c] = 0; m_pe[c] = 0; m_pon[c] = 0; m_poff[c] = 0;
            end
            m_addr = 0; m_us = 0; m_ue = 0; m_aon = 0; m_aoff = 0;
            m_ch = 0; m_round = 0; m_div3 = 0; m_flags = 0;
        end else begin
            if (cen) begin
                mn     = (m_ch + 1) % 6;
                m_us   = m_ps[mn];
                m_ue   = m_pe[mn] && !m_ps[mn];
                m_aon  = m_pon[mn] && !m_ps[mn];
                m_aoff = m_poff[mn];
                if (m_us)      m_addr = m_start[mn];
                else if (m_ue) m_addr = m_end[mn];
                if (m_us)   m_ps[mn] = 0;
                if (m_ue)   m_pe[mn] = 0;
                if (m_aon)  m_pon[mn] = 0;
                if (m_aoff) m_poff[mn] = 0;
                if (m_ch == 5) m_round = (m_round + 1) % 3;
                m_ch   = mn;
                m_div3 = (m_round == 2);
            end
            for (int c = 0; c < 6; c++) begin
                if (flag_clr[c]) m_flags[c] = 1'b0;
                if (cen && done && (int'(ch_done) == c)) m_flags[c] = 1'b1;
            end
            if (cpu_we) begin
                ma = int'(cpu_addr);
                mc = ma % 8;
                if (ma == 0) begin
                    for (int c = 0; c < 6; c++) begin
                        if (cpu_din[c]) begin
                            if (cpu_din[7]) begin m_poff[c] = 1; m_pon[c] = 0; end
                            else            begin m_pon[c] = 1;  m_poff[c] = 0; end
                        end
                    end
                end else if (mc < 6) begin
                    case (ma - mc)
                        16: begin m_start[mc][7:0]  = cpu_din; m_ps[mc] = 1; end
                        24: begin m_start[mc][15:8] = cpu_din; m_ps[mc] = 1; end
                        32: begin m_end[mc][7:0]    = cpu_din; m_pe[mc] = 1; end
                        40: begin m_end[mc][15:8]   = cpu_din; m_pe[mc] = 1; end
                        default: ;
                    endcase
                end
            end
        end
    end

    logic [30:0] act_v, exp_v;
    always @(negedge clk) begin
        if (chk_en) begin
            act_v = {addr_in, up_start, up_end, aon, aoff, ch, div3, flags, busy};
            exp_v = {m_addr, m_us, m_ue, m_aon, m_aoff, 3'(m_ch), m_div3, m_flags, m_busy()};
            n_vec++;
            if (act_v !== exp_v) begin
                n_err++;
                $display("FAIL model_cycle t=%0t: got %h expected %h", $time, act_v, exp_v);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        cpu_we = 1'b1; cpu_addr = a; cpu_din = d;
        @(negedge clk);
        cpu_we = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  a0, d0, a1, d1;
        logic        exp_any;
        logic        exp_start;
        logic [2:0]  exp_ch;
        logic [15:0] exp_addr;
    } vec_t;

    vec_t        tbl [9];
    int          cnt, cnt2, nslot, found;
    logic        g_start;
    logic [2:0]  g_ch;
    logic [15:0] g_addr;
    logic [2:0]  slot_ev [4];
    logic [15:0] slot_addr [4];
    logic        early_aon, seen_start;

    initial begin
        tbl[0] = '{8'h10, 8'h11, 8'h18, 8'h22, 1'b1, 1'b1, 3'd0, 16'h2211};
        tbl[1] = '{8'h15, 8'hA5, 8'h1D, 8'h5A, 1'b1, 1'b1, 3'd5, 16'h5AA5};
        tbl[2] = '{8'h21, 8'h01, 8'h29, 8'h80, 1'b1, 1'b0, 3'd1, 16'h8001};
        tbl[3] = '{8'h24, 8'hFF, 8'h2C, 8'hFF, 1'b1, 1'b0, 3'd4, 16'hFFFF};
        tbl[4] = '{8'h16, 8'h12, 8'h1E, 8'h34, 1'b0, 1'b0, 3'd0, 16'h0000};
        tbl[5] = '{8'h27, 8'h12, 8'h2F, 8'h34, 1'b0, 1'b0, 3'd0, 16'h0000};
        tbl[6] = '{8'h30, 8'h12, 8'h08, 8'h34, 1'b0, 1'b0, 3'd0, 16'h0000};
        tbl[7] = '{8'h13, 8'h77, 8'h13, 8'h99, 1'b1, 1'b1, 3'd3, 16'h0099};
        tbl[8] = '{8'h2A, 8'h12, 8'h2A, 8'h34, 1'b1, 1'b0, 3'd2, 16'h3400};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;

        // reset state
        check("rst_outputs", {addr_in, up_start, up_end, aon, aoff, div3, flags}, 32'h0);
        check("rst_ch", ch, 0);
        check("rst_busy", busy, 0);

        // table of register-pair writes
        for (int i = 0; i < 9; i++) begin
            cen = 1'b0;
            wr(tbl[i].a0, tbl[i].d0);
            wr(tbl[i].a1, tbl[i].d1);
            cen = 1'b1;
            cnt = 0; g_start = 0; g_ch = 0; g_addr = 0;
            for (int k = 0; k < 7; k++) begin
                @(negedge clk);
                if (up_start || up_end) begin
                    if (cnt == 0) begin g_start = up_start; g_ch = ch; g_addr = addr_in; end
                    cnt++;
                end
            end
            check($sformatf("tbl%0d_count", i), cnt, tbl[i].exp_any ? 1 : 0);
            if (tbl[i].exp_any)
                check($sformatf("tbl%0d_issue", i), {g_start, g_ch, g_addr},
                      {tbl[i].exp_start, tbl[i].exp_ch, tbl[i].exp_addr});
            check($sformatf("tbl%0d_busy", i), busy, 0);
        end

        // start address for ch2 in two bytes -> one up_start carrying both
        cen = 1'b0;
        wr(8'h12, 8'h34);
        wr(8'h1A, 8'h12);
        check("t2_busy_set", busy, 1);
        cen = 1'b1;
        cnt = 0; g_ch = 0; g_addr = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (up_start) begin cnt++; g_ch = ch; g_addr = addr_in; end
        end
        check("t2_count", cnt, 1);
        check("t2_issue", {g_ch, g_addr}, {3'd2, 16'h1234});
        check("t2_busy", busy, 0);

        // ch3: start, end and key-on together
        cen = 1'b0;
        wr(8'h13, 8'h44); wr(8'h1B, 8'h33);
        wr(8'h23, 8'h66); wr(8'h2B, 8'h55);
        wr(8'h00, 8'h08);
        cen = 1'b1;
        nslot = 0; early_aon = 0; seen_start = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (aon && !seen_start) early_aon = 1;
            if (up_start && ch == 3'd3) seen_start = 1;
            if (ch == 3'd3) begin
                if (nslot < 4) begin
                    slot_ev[nslot] = {up_start, up_end, aon};
                    slot_addr[nslot] = addr_in;
                end
                nslot++;
            end
        end
        check("t3_slots", nslot, 2);
        check("t3_slotA", {slot_ev[0], slot_addr[0]}, {3'b100, 16'h3344});
        check("t3_slotB", {slot_ev[1], slot_addr[1]}, {3'b011, 16'h5566});
        check("t3_early_aon", early_aon, 0);
        check("t3_busy", busy, 0);

        // key-on for ch0 then key-off before its slot -> only aoff
        cen = 1'b0;
        wr(8'h00, 8'h01);
        wr(8'h00, 8'h81);
        cen = 1'b1;
        cnt = 0; cnt2 = 0; g_ch = 3'd7;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (aon) cnt++;
            if (aoff) begin cnt2++; g_ch = ch; end
        end
        check("t4_aon", cnt, 0);
        check("t4_aoff", cnt2, 1);
        check("t4_aoff_ch", g_ch, 0);
        check("t4_busy", busy, 0);

        // end-low rewrite for ch4 in the same clk its up_end issues
        cen = 1'b0;
        wr(8'h24, 8'hAA);
        wr(8'h2C, 8'hBB);
        cen = 1'b1;
        found = 0;
        for (int k = 0; k < 7; k++) begin
            if (ch == 3'd3) begin found = 1; break; end
            @(negedge clk);
        end
        check("t5_reach", found, 1);
        cpu_we = 1'b1; cpu_addr = 8'h24; cpu_din = 8'h55;
        @(negedge clk);
        cpu_we = 1'b0;
        check("t5_first", {up_end, ch, addr_in}, {1'b1, 3'd4, 16'hBBAA});
        cnt = 0; g_addr = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (up_end) begin cnt++; g_addr = addr_in; end
        end
        check("t5_second_count", cnt, 1);
        check("t5_second_addr", g_addr, 16'hBB55);

        // flags
        cen = 1'b1;
        flag_clr = 6'h3F;
        @(negedge clk);
        flag_clr = 6'h00; done = 1'b1; ch_done = 3'd5;
        @(negedge clk);
        done = 1'b0;
        check("t6_set", flags, 6'b100000);
        done = 1'b1; ch_done = 3'd5; flag_clr = 6'b100000;
        @(negedge clk);
        done = 1'b0; flag_clr = 6'h00;
        check("t6_set_beats_clr", flags, 6'b100000);
        flag_clr = 6'b100000;
        @(negedge clk);
        flag_clr = 6'h00;
        check("t6_clr", flags, 6'b000000);
        done = 1'b1; ch_done = 3'd6;
        @(negedge clk);
        check("t6_ignore_ch6", flags, 6'b000000);
        ch_done = 3'd2; cen = 1'b0;
        @(negedge clk);
        check("t6_no_cen", flags, 6'b000000);
        cen = 1'b1;
        @(negedge clk);
        done = 1'b0;
        check("t6_ch2", flags, 6'b000100);

        // div3 duty
        cnt = 0;
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            if (div3) cnt++;
        end
        check("div3_duty", cnt, 6);

        // randomized phase, checked by the model every cycle
        for (int k = 0; k < 800; k++) begin
            cen    = ($urandom_range(0, 3) != 0);
            cpu_we = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 5))
                0: cpu_addr = 8'h00;
                1: cpu_addr = 8'h10 + 8'($urandom_range(0, 7));
                2: cpu_addr = 8'h18 + 8'($urandom_range(0, 7));
                3: cpu_addr = 8'h20 + 8'($urandom_range(0, 7));
                4: cpu_addr = 8'h28 + 8'($urandom_range(0, 7));
                default: cpu_addr = 8'($urandom);
            endcase
            cpu_din  = 8'($urandom);
            done     = ($urandom_range(0, 7) == 0);
            ch_done  = 3'($urandom_range(0, 7));
            flag_clr = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'h00;
            @(negedge clk);
        end
        cpu_we = 1'b0; done = 1'b0; flag_clr = 6'h00;

        // reset mid-rotation with pending start / key-on
        cen = 1'b0;
        wr(8'h11, 8'h55);
        wr(8'h00, 8'h02);
        check("t1_busy_before", busy, 1);
        cen = 1'b1;
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("t1_outputs", {addr_in, up_start, up_end, aon, aoff, div3, flags}, 32'h0);
        check("t1_ch", ch, 0);
        check("t1_busy", busy, 0);
        #2 rst_n = 1'b1;
        repeat (10) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
